// File: rtl/ext_irq_arbiter_if.sv
// Register bus between exu and the external interrupt arbiter.
// Valid/ready with a fixed one-cycle response and no back-pressure.
interface ext_irq_arbiter_if #(
   parameter int XLEN = 32
);
   logic            i_valid;
   logic            i_wr;
   logic            i_rd;
   logic [XLEN-1:0] i_addr;
   logic [XLEN-1:0] i_wdata;
   logic [XLEN-1:0] o_rdata;
   logic            o_ready;

   modport master (
      output i_valid, i_wr, i_rd, i_addr, i_wdata,
      input  o_rdata, o_ready
   );

   modport slave (
      input  i_valid, i_wr, i_rd, i_addr, i_wdata,
      output o_rdata, o_ready
   );
endinterface

// File: rtl/ext_irq_arbiter.sv
// N-source external interrupt controller: synchronised gateways, pending/enable/priority/threshold
// registers, claim/complete protocol and a registered meip toward the CSR unit.
module ext_irq_arbiter #(
   parameter int               N_SRC  = 8,
   parameter int               PRIO_W = 3,
   parameter logic [N_SRC-1:0] EDGE   = '0,
   parameter int               XLEN   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SRC-1:0] i_src,
   ext_irq_arbiter_if.slave bus,
   output logic             o_meip,
   output logic [4:0]       o_claim_id
);

   localparam logic [5:0] W_PENDING   = 6'd0;
   localparam logic [5:0] W_ENABLE    = 6'd1;
   localparam logic [5:0] W_THRESHOLD = 6'd2;
   localparam logic [5:0] W_CLAIM     = 6'd3;
   localparam int         W_PRIO_BASE = 4;

   logic [N_SRC-1:0]  sync_q1, sync_q2, sync_d;
   logic [N_SRC-1:0]  pending, enable, in_service;
   logic [PRIO_W-1:0] threshold;
   logic [PRIO_W-1:0] prio [N_SRC];

   logic [N_SRC-1:0]  rise, claim_clr, cmp_clr, pend_nx, insvc_nx;
   logic [4:0]        win_id;
   logic [PRIO_W-1:0] win_prio;
   logic [5:0]        word;
   logic              do_wr, do_rd, claim, complete;
   logic [4:0]        cmp_id;
   logic [XLEN-1:0]   rd_val;

   assign word     = bus.i_addr[7:2];
   assign do_wr    = bus.i_valid & bus.i_wr;
   assign do_rd    = bus.i_valid & bus.i_rd & ~bus.i_wr;
   assign claim    = do_rd && (word == W_CLAIM);
   assign complete = do_wr && (word == W_CLAIM);
   assign cmp_id   = bus.i_wdata[4:0];
   assign rise     = sync_q2 & ~sync_d;

   // Ascending scan with strict compare leaves the lowest ID on a priority tie.
   always_comb begin
      win_id   = '0;
      win_prio = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (enable[i] && pending[i] && (prio[i] > threshold) && (prio[i] > win_prio)) begin
            win_id   = 5'(i + 1);
            win_prio = prio[i];
         end
      end
   end

   always_comb begin
      claim_clr = '0;
      cmp_clr   = '0;
      pend_nx   = '0;
      for (int i = 0; i < N_SRC; i++) begin
         claim_clr[i] = claim && (win_id == 5'(i + 1));
         cmp_clr[i]   = complete && (cmp_id == 5'(i + 1)) && in_service[i];
         // An edge arriving with the claim survives; a level source is gated by in-service instead.
         if (EDGE[i])
            pend_nx[i] = (pending[i] & ~claim_clr[i]) | rise[i];
         else
            pend_nx[i] = ~claim_clr[i] & (pending[i] | (sync_q2[i] & ~in_service[i]));
      end
      insvc_nx = (in_service | claim_clr) & ~cmp_clr;
   end

   always_comb begin
      rd_val = '0;
      case (word)
         W_PENDING:   rd_val = XLEN'({pending, 1'b0});
         W_ENABLE:    rd_val = XLEN'({enable, 1'b0});
         W_THRESHOLD: rd_val = XLEN'(threshold);
         W_CLAIM:     rd_val = XLEN'(win_id);
         default: begin
            for (int i = 0; i < N_SRC; i++)
               if (word == 6'(i + W_PRIO_BASE)) rd_val = XLEN'(prio[i]);
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q1     <= '0;
         sync_q2     <= '0;
         sync_d      <= '0;
         pending     <= '0;
         enable      <= '0;
         in_service  <= '0;
         threshold   <= '0;
         o_meip      <= 1'b0;
         o_claim_id  <= '0;
         bus.o_ready <= 1'b0;
         bus.o_rdata <= '0;
         for (int i = 0; i < N_SRC; i++) prio[i] <= '0;
      end else begin
         sync_q1     <= i_src;
         sync_q2     <= sync_q1;
         sync_d      <= sync_q2;
         pending     <= pend_nx;
         in_service  <= insvc_nx;
         o_meip      <= (win_id != 5'd0);
         o_claim_id  <= win_id;
         bus.o_ready <= bus.i_valid;
         bus.o_rdata <= do_rd ? rd_val : '0;
         if (do_wr && (word == W_ENABLE))    enable    <= bus.i_wdata[N_SRC:1];
         if (do_wr && (word == W_THRESHOLD)) threshold <= bus.i_wdata[PRIO_W-1:0];
         for (int i = 0; i < N_SRC; i++)
            if (do_wr && (word == 6'(i + W_PRIO_BASE))) prio[i] <= bus.i_wdata[PRIO_W-1:0];
      end
   end

endmodule
